banked_ram: RTL and testbench

//  Parametrised successor of the SoC byte-lane RAM. Holds separate instruction (IRAM) and data (DRAM)

---
 rtl/banked_ram.sv | 221 ++++++++++++++++++++++
 tb/tb_banked_ram.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_ram.sv
// banked_ram: instruction and data memories, each built from LANES byte-wide banks.
// Word accesses at any byte alignment are served in one cycle by giving every bank
// its own word index and rotating data lanes by the byte offset. The fetch port and
// the data port each have a one-deep response register that holds under backpressure.
// A byte-wide loader port fills both memories while ld_sel_i is high.
module banked_ram #(
    parameter int         XLEN  = 32,
    parameter int         LANES = 4,
    parameter int         DEPTH = 4096,
    parameter logic [7:0] ITAG  = 8'h00,
    parameter logic [7:0] DTAG  = 8'h10
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             ld_sel_i,
    input  logic [XLEN-1:0]  ld_addr_i,
    input  logic             ld_we_i,
    input  logic [7:0]       ld_wr_data_i,
    output logic [7:0]       ld_rd_data_o,

    input  logic             i_req_valid_i,
    output logic             i_req_ready_o,
    input  logic [XLEN-1:0]  i_addr_i,
    output logic             i_rsp_valid_o,
    input  logic             i_rsp_ready_i,
    output logic [XLEN-1:0]  i_rsp_data_o,
    output logic             i_rsp_err_o,

    input  logic             d_req_valid_i,
    output logic             d_req_ready_o,
    input  logic             d_req_we_i,
    input  logic [XLEN-1:0]  d_addr_i,
    input  logic [XLEN-1:0]  d_wr_data_i,
    input  logic [LANES-1:0] d_byte_en_i,
    output logic             d_rsp_valid_o,
    input  logic             d_rsp_ready_i,
    output logic [XLEN-1:0]  d_rsp_data_o,
    output logic             d_rsp_err_o
);

    localparam int OW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);

    typedef logic [OW-1:0] lane_t;
    typedef logic [AW-1:0] idx_t;

    // Byte banks: first index is the bank (lane), second the word index.
    logic [7:0] iram [LANES][DEPTH];
    logic [7:0] dram [LANES][DEPTH];

    // ------------------------------------------------------------------
    // Fetch port decode
    // ------------------------------------------------------------------
    logic            i_hit;
    lane_t           i_off;
    idx_t            i_w;
    idx_t            i_idx [LANES];
    lane_t           i_src [LANES];
    logic [XLEN-1:0] i_word;
    logic            i_accept;

    assign i_hit    = (i_addr_i[XLEN-1:XLEN-8] == ITAG);
    assign i_off    = i_addr_i[OW-1:0];
    assign i_w      = i_addr_i[AW+OW-1:OW];
    assign i_accept = i_req_valid_i && i_req_ready_o;

    // Banks below the byte offset belong to the following word (wrapping at DEPTH).
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            i_idx[k] = (lane_t'(k) < i_off) ? i_w + idx_t'(1) : i_w;
            i_src[k] = i_off + lane_t'(k);
        end
    end

    // Gather the fetched word: result byte j comes from bank (off + j) mod LANES.
    always_comb begin
        i_word = '0;
        for (int j = 0; j < LANES; j++) begin
            if (i_hit) begin
                i_word[8*j +: 8] = iram[i_src[j]][i_idx[i_src[j]]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Data port decode
    // ------------------------------------------------------------------
    logic            d_hit;
    lane_t           d_off;
    idx_t            d_w;
    idx_t            d_idx [LANES];
    lane_t           d_src [LANES];
    lane_t           d_rel [LANES];
    logic [7:0]      d_wbyte [LANES];
    logic [LANES-1:0] d_wen;
    logic [XLEN-1:0] d_word;
    logic            d_accept;
    logic            d_commit;

    assign d_hit    = (d_addr_i[XLEN-1:XLEN-8] == DTAG);
    assign d_off    = d_addr_i[OW-1:0];
    assign d_w      = d_addr_i[AW+OW-1:OW];
    assign d_accept = d_req_valid_i && d_req_ready_o;
    assign d_commit = d_accept && d_req_we_i && d_hit;

    // Per-bank index, read source lane and the write byte each bank receives.
    always_comb begin
        d_wen = '0;
        for (int k = 0; k < LANES; k++) begin
            d_idx[k]   = (lane_t'(k) < d_off) ? d_w + idx_t'(1) : d_w;
            d_src[k]   = d_off + lane_t'(k);
            d_rel[k]   = lane_t'(k) - d_off;
            d_wbyte[k] = d_wr_data_i[8*d_rel[k] +: 8];
            d_wen[k]   = d_byte_en_i[d_rel[k]];
        end
    end

    // Gather the data word with the same rotation as the fetch side.
    always_comb begin
        d_word = '0;
        for (int j = 0; j < LANES; j++) begin
            if (d_hit) begin
                d_word[8*j +: 8] = dram[d_src[j]][d_idx[d_src[j]]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Loader decode
    // ------------------------------------------------------------------
    logic  ld_ihit;
    logic  ld_dhit;
    lane_t ld_bank;
    idx_t  ld_w;
    logic  ld_wr_i;
    logic  ld_wr_d;

    assign ld_ihit = (ld_addr_i[XLEN-1:XLEN-8] == ITAG);
    assign ld_dhit = (ld_addr_i[XLEN-1:XLEN-8] == DTAG);
    assign ld_bank = ld_addr_i[OW-1:0];
    assign ld_w    = ld_addr_i[AW+OW-1:OW];
    assign ld_wr_i = ld_sel_i && ld_we_i && ld_ihit;
    assign ld_wr_d = ld_sel_i && ld_we_i && ld_dhit;

    // Address bits between the tag and the word index select nothing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr_i[XLEN-9:AW+OW], d_addr_i[XLEN-9:AW+OW],
                                ld_addr_i[XLEN-9:AW+OW]};

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign i_req_ready_o = !ld_sel_i && !rst_i && (!i_rsp_valid_o || i_rsp_ready_i);
    assign d_req_ready_o = !ld_sel_i && !rst_i && (!d_rsp_valid_o || d_rsp_ready_i);

    // IRAM is written only by the loader; reset blocks the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ld_wr_i) begin
            iram[ld_bank][ld_w] <= ld_wr_data_i;
        end
    end

    // DRAM takes loader bytes or rotated port writes; the two never coincide because ld_sel_i blocks the port.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (ld_wr_d) begin
                dram[ld_bank][ld_w] <= ld_wr_data_i;
            end
            for (int k = 0; k < LANES; k++) begin
                if (d_commit && d_wen[k]) begin
                    dram[k][d_idx[k]] <= d_wbyte[k];
                end
            end
        end
    end

    // Loader read byte, registered from last cycle's address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_rd_data_o <= '0;
        end else if (ld_ihit) begin
            ld_rd_data_o <= iram[ld_bank][ld_w];
        end else if (ld_dhit) begin
            ld_rd_data_o <= dram[ld_bank][ld_w];
        end else begin
            ld_rd_data_o <= '0;
        end
    end

    // Fetch response register: load on accept, clear valid once consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_rsp_valid_o <= 1'b0;
            i_rsp_data_o  <= '0;
            i_rsp_err_o   <= 1'b0;
        end else if (i_accept) begin
            i_rsp_valid_o <= 1'b1;
            i_rsp_data_o  <= i_word;
            i_rsp_err_o   <= !i_hit;
        end else if (i_rsp_ready_i) begin
            i_rsp_valid_o <= 1'b0;
        end
    end

    // Data response register: read data for hits, zero for writes and errors.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_rsp_valid_o <= 1'b0;
            d_rsp_data_o  <= '0;
            d_rsp_err_o   <= 1'b0;
        end else if (d_accept) begin
            d_rsp_valid_o <= 1'b1;
            d_rsp_data_o  <= (d_hit && !d_req_we_i) ? d_word : '0;
            d_rsp_err_o   <= !d_hit;
        end else if (d_rsp_ready_i) begin
            d_rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_banked_ram.sv
// tb_banked_ram: directed tests for banked_ram with hand-computed expected values.
module tb_banked_ram;

    logic        clk;
    logic        rst;
    logic        ld_sel;
    logic [31:0] ld_addr;
    logic        ld_we;
    logic [7:0]  ld_wr_data;
    logic [7:0]  ld_rd_data;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_addr;
    logic        i_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic [3:0]  d_byte_en;
    logic        d_rsp_valid;
    logic        d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;

    int checks = 0;
    int errors = 0;

    banked_ram dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ld_sel_i      (ld_sel),
        .ld_addr_i     (ld_addr),
        .ld_we_i       (ld_we),
        .ld_wr_data_i  (ld_wr_data),
        .ld_rd_data_o  (ld_rd_data),
        .i_req_valid_i (i_req_valid),
        .i_req_ready_o (i_req_ready),
        .i_addr_i      (i_addr),
        .i_rsp_valid_o (i_rsp_valid),
        .i_rsp_ready_i (i_rsp_ready),
        .i_rsp_data_o  (i_rsp_data),
        .i_rsp_err_o   (i_rsp_err),
        .d_req_valid_i (d_req_valid),
        .d_req_ready_o (d_req_ready),
        .d_req_we_i    (d_req_we),
        .d_addr_i      (d_addr),
        .d_wr_data_i   (d_wr_data),
        .d_byte_en_i   (d_byte_en),
        .d_rsp_valid_o (d_rsp_valid),
        .d_rsp_ready_i (d_rsp_ready),
        .d_rsp_data_o  (d_rsp_data),
        .d_rsp_err_o   (d_rsp_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic ld_write(input logic [31:0] addr, input logic [7:0] data);
        ld_addr = addr; ld_wr_data = data; ld_we = 1'b1;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic ld_read(input logic [31:0] addr, output logic [7:0] data);
        ld_addr = addr;
        @(posedge clk); #1;
        data = ld_rd_data;
    endtask

    task automatic d_issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        d_req_valid = 1'b1; d_req_we = we; d_addr = addr; d_wr_data = wd; d_byte_en = be;
        @(posedge clk); #1;
        d_req_valid = 1'b0; d_req_we = 1'b0;
    endtask

    task automatic i_issue(input logic [31:0] addr);
        i_req_valid = 1'b1; i_addr = addr;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_valid actual=%b required=0", d_rsp_valid); end
        checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_i_valid actual=%b required=0", i_rsp_valid); end
        checks++; if (d_rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_d_data actual=%h required=0", d_rsp_data); end
        checks++; if (i_rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_i_data actual=%h required=0", i_rsp_data); end
        checks++; if ({d_rsp_err, i_rsp_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_err actual=%b required=00", {d_rsp_err, i_rsp_err}); end
        checks++; if (ld_rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_ld_data actual=%h required=00", ld_rd_data); end
        checks++; if ({d_req_ready, i_req_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready actual=%b required=00", {d_req_ready, i_req_ready}); end
        rst = 1'b0;
        #1;
        checks++; if ({d_req_ready, i_req_ready} !== 2'b11) begin errors++; $display("[TB] FAIL post_reset_ready actual=%b required=11", {d_req_ready, i_req_ready}); end
    endtask

    task automatic test_aligned_read();
        ld_sel = 1'b1;
        #1;
        checks++; if ({d_req_ready, i_req_ready} !== 2'b00) begin errors++; $display("[TB] FAIL loader_blocks_ready actual=%b required=00", {d_req_ready, i_req_ready}); end
        ld_write(32'h1000_0000, 8'h11);
        ld_write(32'h1000_0001, 8'h22);
        ld_write(32'h1000_0002, 8'h33);
        ld_write(32'h1000_0003, 8'h44);
        ld_sel = 1'b0;
        d_issue(1'b0, 32'h1000_0000, 32'h0, 4'h0);
        checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL aligned_valid actual=%b required=1", d_rsp_valid); end
        checks++; if (d_rsp_data !== 32'h4433_2211) begin errors++; $display("[TB] FAIL aligned_data actual=%h required=44332211", d_rsp_data); end
        checks++; if (d_rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL aligned_err actual=%b required=0", d_rsp_err); end
        @(posedge clk); #1;
        checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL aligned_consumed actual=%b required=0", d_rsp_valid); end
    endtask

    task automatic test_unaligned();
        logic [7:0] b;
        d_issue(1'b1, 32'h1000_0003, 32'hAABB_CCDD, 4'b1111);
        checks++; if ({d_rsp_valid, d_rsp_err} !== 2'b10) begin errors++; $display("[TB] FAIL uwrite_rsp actual=%b required=10", {d_rsp_valid, d_rsp_err}); end
        checks++; if (d_rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL uwrite_data actual=%h required=0", d_rsp_data); end
        d_issue(1'b0, 32'h1000_0003, 32'h0, 4'h0);
        checks++; if (d_rsp_data !== 32'hAABB_CCDD) begin errors++; $display("[TB] FAIL uread_data actual=%h required=aabbccdd", d_rsp_data); end
        ld_sel = 1'b1;
        ld_read(32'h1000_0006, b);
        checks++; if (b !== 8'hAA) begin errors++; $display("[TB] FAIL ld_read_6 actual=%h required=aa", b); end
        ld_read(32'h1000_0003, b);
        checks++; if (b !== 8'hDD) begin errors++; $display("[TB] FAIL ld_read_3 actual=%h required=dd", b); end
        ld_sel = 1'b0;
        d_issue(1'b1, 32'h1000_0001, 32'h0000_0099, 4'b0001);
        d_issue(1'b0, 32'h1000_0000, 32'h0, 4'h0);
        checks++; if (d_rsp_data !== 32'hDD33_9911) begin errors++; $display("[TB] FAIL partial_be actual=%h required=dd339911", d_rsp_data); end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        ld_sel = 1'b1;
        ld_write(32'h0000_3FFE, 8'hA1);
        ld_write(32'h0000_3FFF, 8'hA2);
        ld_write(32'h0000_0000, 8'hA3);
        ld_write(32'h0000_0001, 8'hA4);
        ld_write(32'h0000_0002, 8'hA5);
        ld_read(32'h3000_0000, b);
        checks++; if (b !== 8'h00) begin errors++; $display("[TB] FAIL ld_unmapped actual=%h required=00", b); end
        ld_sel = 1'b0;
        i_issue(32'h0000_3FFE);
        checks++; if ({i_rsp_valid, i_rsp_err} !== 2'b10) begin errors++; $display("[TB] FAIL wrap_rsp actual=%b required=10", {i_rsp_valid, i_rsp_err}); end
        checks++; if (i_rsp_data !== 32'hA4A3_A2A1) begin errors++; $display("[TB] FAIL wrap_data actual=%h required=a4a3a2a1", i_rsp_data); end
        i_issue(32'h0100_0000);
        checks++; if (i_rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL fetch_err actual=%b required=1", i_rsp_err); end
        checks++; if (i_rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL fetch_err_data actual=%h required=0", i_rsp_data); end
    endtask

    task automatic test_backpressure();
        d_rsp_ready = 1'b0;
        d_issue(1'b0, 32'h1000_0000, 32'h0, 4'h0);
        d_req_valid = 1'b1; d_req_we = 1'b0; d_addr = 32'h1000_0003;
        for (int c = 0; c < 3; c++) begin
            checks++; if (d_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_c%0d actual=%b required=0", c, d_req_ready); end
            checks++; if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'hDD33_9911}) begin errors++; $display("[TB] FAIL bp_hold_c%0d actual=%b/%h required=1/dd339911", c, d_rsp_valid, d_rsp_data); end
            @(posedge clk); #1;
        end
        d_rsp_ready = 1'b1;
        #1;
        checks++; if (d_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready actual=%b required=1", d_req_ready); end
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        checks++; if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'hAABB_CCDD}) begin errors++; $display("[TB] FAIL bp_next_rsp actual=%b/%h required=1/aabbccdd", d_rsp_valid, d_rsp_data); end
    endtask

    task automatic test_error();
        d_issue(1'b0, 32'h2000_0000, 32'h0, 4'h0);
        checks++; if ({d_rsp_valid, d_rsp_err} !== 2'b11) begin errors++; $display("[TB] FAIL err_read_flags actual=%b required=11", {d_rsp_valid, d_rsp_err}); end
        checks++; if (d_rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL err_read_data actual=%h required=0", d_rsp_data); end
        d_issue(1'b1, 32'h2000_0000, 32'h5566_7788, 4'b1111);
        checks++; if (d_rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL err_write_flag actual=%b required=1", d_rsp_err); end
        d_issue(1'b0, 32'h1000_0000, 32'h0, 4'h0);
        checks++; if ({d_rsp_err, d_rsp_data} !== {1'b0, 32'hDD33_9911}) begin errors++; $display("[TB] FAIL err_write_no_effect actual=%b/%h required=0/dd339911", d_rsp_err, d_rsp_data); end
    endtask

    task automatic test_back_to_back();
        d_req_valid = 1'b1; d_req_we = 1'b0; d_addr = 32'h1000_0000;
        i_req_valid = 1'b1; i_addr = 32'h0000_3FFE;
        @(posedge clk); #1;
        checks++; if (d_rsp_data !== 32'hDD33_9911) begin errors++; $display("[TB] FAIL b2b_d0 actual=%h required=dd339911", d_rsp_data); end
        checks++; if (i_rsp_data !== 32'hA4A3_A2A1) begin errors++; $display("[TB] FAIL b2b_i0 actual=%h required=a4a3a2a1", i_rsp_data); end
        checks++; if ({d_req_ready, i_req_ready} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_ready actual=%b required=11", {d_req_ready, i_req_ready}); end
        d_addr = 32'h1000_0003;
        i_addr = 32'h0000_3FFF;
        @(posedge clk); #1;
        d_req_valid = 1'b0; i_req_valid = 1'b0;
        checks++; if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'hAABB_CCDD}) begin errors++; $display("[TB] FAIL b2b_d1 actual=%b/%h required=1/aabbccdd", d_rsp_valid, d_rsp_data); end
        checks++; if ({i_rsp_valid, i_rsp_data} !== {1'b1, 32'hA5A4_A3A2}) begin errors++; $display("[TB] FAIL b2b_i1 actual=%b/%h required=1/a5a4a3a2", i_rsp_valid, i_rsp_data); end
    endtask

    task automatic test_reset_write();
        i_rsp_ready = 1'b0;
        i_issue(32'h0000_3FFE);
        checks++; if (i_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rw_pending actual=%b required=1", i_rsp_valid); end
        rst = 1'b1;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_addr = 32'h1000_0000; d_wr_data = 32'hFFFF_FFFF; d_byte_en = 4'b1111;
        @(posedge clk); #1;
        checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rw_valid actual=%b required=00", {i_rsp_valid, d_rsp_valid}); end
        checks++; if ({i_rsp_data, d_rsp_data} !== 64'h0) begin errors++; $display("[TB] FAIL rw_data actual=%h/%h required=0/0", i_rsp_data, d_rsp_data); end
        checks++; if ({i_rsp_err, d_rsp_err, d_req_ready, i_req_ready, ld_rd_data} !== 12'h0) begin errors++; $display("[TB] FAIL rw_misc actual=%b%b%b%b/%h required=0", i_rsp_err, d_rsp_err, d_req_ready, i_req_ready, ld_rd_data); end
        d_req_valid = 1'b0; d_req_we = 1'b0;
        rst = 1'b0;
        i_rsp_ready = 1'b1;
        d_issue(1'b0, 32'h1000_0000, 32'h0, 4'h0);
        checks++; if (d_rsp_data !== 32'hDD33_9911) begin errors++; $display("[TB] FAIL rw_mem_unchanged actual=%h required=dd339911", d_rsp_data); end
    endtask

    // Sequence of directed scenarios followed by the summary.
    initial begin
        rst = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_we = 1'b0; ld_wr_data = '0;
        i_req_valid = 1'b0; i_addr = '0; i_rsp_ready = 1'b1;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_addr = '0; d_wr_data = '0; d_byte_en = '0; d_rsp_ready = 1'b1;
        test_reset();
        test_aligned_read();
        test_unaligned();
        test_wrap();
        test_backpressure();
        test_error();
        test_back_to_back();
        test_reset_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
